// File: rtl/ifq_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under a credit limit,
// buffers returned {pc, icode} pairs and serves them to dispatch, flushing on jumps.
module ifq_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dpch_rd,
    input  logic        dpch_jmp,
    input  logic [31:0] dpch_jmp_br_addr,
    output logic [31:0] ifq_pc,
    output logic [31:0] ifq_icode,
    output logic        ifq_empty,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   icode_mem [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [31:0]   occupancy;
    logic [OW-1:0] outstanding_next;

    // Issue credit, response routing and pop qualification for this cycle.
    always_comb begin
        occupancy        = 32'(count) + 32'(outstanding);
        issue            = ~rst & ~dpch_jmp & (occupancy < 32'(DEPTH))
                         & (32'(outstanding) < 32'(MAX_OUT));
        outstanding_next = outstanding + OW'(issue) - OW'(mem_rdata_valid);
        push             = mem_rdata_valid & (drop == {OW{1'b0}}) & ~dpch_jmp;
        pop              = dpch_rd & (count != {CW{1'b0}}) & ~dpch_jmp;
    end

    assign mem_rd_en = issue;
    assign mem_addr  = fetch_pc;
    assign ifq_empty = (count == {CW{1'b0}});
    assign ifq_pc    = ifq_empty ? 32'h0000_0000 : pc_mem[rd_ptr];
    assign ifq_icode = ifq_empty ? 32'h0000_0000 : icode_mem[rd_ptr];

    // FIFO storage; the credit limit guarantees a push never lands on a live entry.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            icode_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Fetch/response address tracking, occupancy and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= {CW{1'b0}};
            outstanding <= {OW{1'b0}};
            drop        <= {OW{1'b0}};
            wr_ptr      <= {AW{1'b0}};
            rd_ptr      <= {AW{1'b0}};
        end else if (dpch_jmp) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc    <= dpch_jmp_br_addr;
            resp_pc     <= dpch_jmp_br_addr;
            count       <= {CW{1'b0}};
            outstanding <= outstanding_next;
            drop        <= outstanding_next;
            wr_ptr      <= {AW{1'b0}};
            rd_ptr      <= {AW{1'b0}};
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (mem_rdata_valid) begin
                if (drop != {OW{1'b0}}) begin
                    drop <= drop - OW'(1);
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding_next;
        end
    end
endmodule

// File: tb/tb_ifq_fetch_queue.sv
// Bench for ifq_fetch_queue: random-latency in-order memory, epoch-tagged
// reference model of the fetch stream, and a scoreboard monitor on the head.
module tb_ifq_fetch_queue;
    localparam int          DEPTH    = 8;
    localparam int          MAX_OUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dpch_rd = 1'b0;
    logic        dpch_jmp = 1'b0;
    logic [31:0] dpch_jmp_br_addr = 32'h0;
    logic [31:0] ifq_pc;
    logic [31:0] ifq_icode;
    logic        ifq_empty;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rdata_valid = 1'b0;

    ifq_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .dpch_rd(dpch_rd), .dpch_jmp(dpch_jmp),
        .dpch_jmp_br_addr(dpch_jmp_br_addr), .ifq_pc(ifq_pc), .ifq_icode(ifq_icode),
        .ifq_empty(ifq_empty), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    int          occ = 0;
    int          epoch = 0;
    int          cyc = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    int          first_req = -1;
    int          n_pass = 0;
    int          n_total = 0;
    bit          rd_req = 1'b0;
    bit          jmp_req = 1'b0;
    logic [31:0] jaddr_req = 32'h0;

    function automatic logic [31:0] icode_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // A new program-order stream starts at a: dispatch must see a, a+4, a+8, ...
    function automatic void restart_stream(input logic [31:0] a);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(a + 32'(4 * i));
        exp_fetch = a;
        occ = 0;
        epoch++;
    endfunction

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic step();
        int  outs;
        bit  have_resp;
        int  r_epoch;
        int  lat;
        bit  exp_en;
        bit  popped;
        outs      = pend.size();
        have_resp = 1'b0;
        r_epoch   = -1;
        mem_rdata = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            have_resp = 1'b1;
            r_epoch   = pend[0].epoch;
            mem_rdata = icode_of(pend[0].addr);
            void'(pend.pop_front());
        end
        mem_rdata_valid  = have_resp;
        dpch_rd          = rd_req;
        dpch_jmp         = jmp_req;
        dpch_jmp_br_addr = jaddr_req;
        #1;
        chk("outstanding_bound", 32'(outs <= MAX_OUT), 32'd1);
        chk("credit_bound", 32'(occ + outs <= DEPTH), 32'd1);
        exp_en = !jmp_req && (occ + outs < DEPTH) && (outs < MAX_OUT);
        chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_en));
        if (mem_rd_en) begin
            chk("mem_addr", mem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            lat = $urandom_range(lat_hi, lat_lo);
            pend.push_back('{mem_addr, cyc + lat, epoch});
            req_cnt++;
            if (first_req < 0) first_req = cyc;
        end
        popped = rd_req && (occ > 0) && !jmp_req;
        @(posedge clk);
        if (jmp_req) begin
            restart_stream(jaddr_req);
        end else begin
            if (have_resp && r_epoch == epoch) occ++;
            if (popped) begin
                occ--;
                pop_cnt++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset in mid-cycle; outputs must follow immediately.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_empty", 32'(ifq_empty), 32'd1);
        chk("rst_pc", ifq_pc, 32'h0);
        chk("rst_icode", ifq_icode, 32'h0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        pend.delete();
        restart_stream(RESET_PC);
        req_cnt = 0;
        first_req = -1;
        rd_req = 1'b0;
        jmp_req = 1'b0;
        dpch_rd = 1'b0;
        dpch_jmp = 1'b0;
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares the presented head against the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("empty_flag", 32'(ifq_empty), 32'(occ == 0));
                if (ifq_empty) begin
                    chk("empty_pc_zero", ifq_pc, 32'h0);
                    chk("empty_icode_zero", ifq_icode, 32'h0);
                end else begin
                    e = exp_q[0];
                    chk("head_pc", ifq_pc, e);
                    chk("head_icode", ifq_icode, icode_of(e));
                    if (dpch_rd && !dpch_jmp) begin
                        void'(exp_q.pop_front());
                        exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  hit;
        @(negedge clk);
        do_reset();

        // Fill with no dispatch: exactly DEPTH requests, then stall.
        lat_lo = 1; lat_hi = 1;
        repeat (14) step();
        chk("fill_req_count", 32'(req_cnt), 32'd8);
        chk("fill_rd_en_off", 32'(mem_rd_en), 32'd0);
        chk("fill_not_empty", 32'(ifq_empty), 32'd0);
        chk("fill_head_pc", ifq_pc, RESET_PC);

        // Steady stream: one instruction per cycle after fill.
        do_reset();
        rd_req = 1'b1;
        repeat (2) step();
        pop_cnt = 0;
        repeat (20) step();
        chk("stream_no_gaps", 32'(pop_cnt), 32'd20);

        // Latency 3: first entry visible 4 cycles after the first request.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        rd_req = 1'b0;
        k = -1;
        for (int i = 0; i < 20; i++) begin
            if (!ifq_empty && k < 0) k = cyc - first_req;
            step();
        end
        chk("lat3_first_visible", 32'(k), 32'd4);

        // Jump with 3 in flight and 5 queued.
        hit = 1'b0;
        do_reset();
        for (int i = 0; i < 40 && !hit; i++) begin
            if (occ == 5 && pend.size() == 3) hit = 1'b1;
            else step();
        end
        chk("jmp_setup_reached", 32'(hit), 32'd1);
        jmp_req = 1'b1; jaddr_req = 32'h0040_0100;
        step();
        jmp_req = 1'b0;
        chk("jmp_flush_empty", 32'(ifq_empty), 32'd1);
        for (int i = 0; i < 20 && ifq_empty; i++) step();
        chk("jmp_first_pc", ifq_pc, 32'h0040_0100);
        chk("jmp_first_icode", ifq_icode, icode_of(32'h0040_0100));

        // Dispatch reads while empty, then a single late response.
        do_reset();
        lat_lo = 12; lat_hi = 12;
        rd_req = 1'b1;
        repeat (10) step();
        chk("rd_empty_still_empty", 32'(ifq_empty), 32'd1);
        for (int i = 0; i < 10 && ifq_empty; i++) step();
        chk("late_resp_head_pc", ifq_pc, RESET_PC);
        chk("late_resp_head_icode", ifq_icode, icode_of(RESET_PC));

        // Back-to-back jumps with responses in flight.
        do_reset();
        lat_lo = 2; lat_hi = 2;
        rd_req = 1'b0;
        repeat (6) step();
        jmp_req = 1'b1; jaddr_req = 32'h0040_0200; step();
        jaddr_req = 32'h0040_0300; step();
        jmp_req = 1'b0; rd_req = 1'b1;
        pop_cnt = 0;
        repeat (30) step();
        chk("dbl_jmp_progress", 32'(pop_cnt >= 20), 32'd1);
        do_reset();

        // Randomized traffic with redirects, wrap-around targets and resets.
        for (int i = 0; i < 2400; i++) begin
            if (i % 300 == 0) begin
                lat_lo = 1;
                lat_hi = $urandom_range(5, 1);
            end
            rd_req  = ($urandom_range(99, 0) < 70);
            jmp_req = ($urandom_range(99, 0) < 4);
            jaddr_req = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            step();
            if (i % 800 == 799) do_reset();
        end
        jmp_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
